weight_load_ctrl: RTL

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

---
 rtl/weight_load_ctrl_if.sv | 31 +++
 rtl/weight_load_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl_if.sv
// rtl/weight_load_ctrl_if.sv - weight stream, weight-buffer write and conv-engine handshake bundle
interface weight_load_ctrl_if #(
  parameter int INPUT_WIDTH = 32
);
  // weight stream from the fetch side
  logic [INPUT_WIDTH-1:0] S_TDATA;
  logic                   S_TVALID;
  logic                   S_TLAST;
  logic                   S_TREADY;
  // weight-buffer write port
  logic                   WB_WR_EN;
  logic                   WB_WR_VALID;
  logic [INPUT_WIDTH-1:0] WB_WR_DATA;
  logic                   WB_RESETN;
  logic                   WB_FULL;
  // convolution engine handshake
  logic                   CONV_START;
  logic                   CONV_DONE;

  // controller side
  modport slave (
    input  S_TDATA, S_TVALID, S_TLAST, WB_FULL, CONV_DONE,
    output S_TREADY, WB_WR_EN, WB_WR_VALID, WB_WR_DATA, WB_RESETN, CONV_START
  );

  // environment side (stream source, buffer, engine)
  modport master (
    output S_TDATA, S_TVALID, S_TLAST, WB_FULL, CONV_DONE,
    input  S_TREADY, WB_WR_EN, WB_WR_VALID, WB_WR_DATA, WB_RESETN, CONV_START
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - sequences kernel loads into the weight buffer and convolution runs
module weight_load_ctrl #(
  parameter int INPUT_WIDTH      = 32,
  parameter int WORDS_PER_KERNEL = 7,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic [CNT_WIDTH-1:0] NUM_FILTERS,
  input  logic                 ABORT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR_LAST,
  output logic [CNT_WIDTH-1:0] FILTER_IDX,
  weight_load_ctrl_if.slave    bus
);

  localparam int WCW = (WORDS_PER_KERNEL > 1) ? $clog2(WORDS_PER_KERNEL) : 1;
  localparam logic [WCW-1:0]       LAST_WORD = WCW'(WORDS_PER_KERNEL - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_FULL,
    ST_CONV,
    ST_FINISH
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_WIDTH-1:0]   r_num;
  logic [CNT_WIDTH-1:0]   r_idx;
  logic [WCW-1:0]         r_wcnt;
  logic                   r_err;
  logic                   r_zero_done;
  logic                   r_abort_pulse;
  logic                   r_conv_start;

  logic                   w_busy_state;
  logic                   w_abort;
  logic                   w_start_ok;
  logic                   w_beat;
  logic                   w_kernel_end;
  logic                   w_last_filter;
  logic                   w_final_beat;
  logic [INPUT_WIDTH-1:0] w_tdata;

  assign w_busy_state  = (r_state != ST_IDLE);
  assign w_abort       = ABORT && w_busy_state;
  assign w_start_ok    = (r_state == ST_IDLE) && START && (NUM_FILTERS != '0);
  // S_TREADY is high throughout LOAD, so a beat is just valid while loading
  assign w_beat        = (r_state == ST_LOAD) && bus.S_TVALID;
  assign w_kernel_end  = w_beat && (r_wcnt == LAST_WORD);
  assign w_last_filter = (r_idx == (r_num - CNT_ONE));
  assign w_final_beat  = w_kernel_end && w_last_filter;
  assign w_tdata       = bus.S_TDATA;

  // state register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode; abort overrides every other event once a run is active
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_start_ok) w_next_state = ST_LOAD;
      ST_LOAD:      if (w_kernel_end) w_next_state = ST_WAIT_FULL;
      ST_WAIT_FULL: if (bus.WB_FULL) w_next_state = ST_CONV;
      ST_CONV:      if (bus.CONV_DONE) w_next_state = w_last_filter ? ST_FINISH : ST_LOAD;
      ST_FINISH:    w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = ST_IDLE;
    end
  end

  // run bookkeeping: filter count/index, word counter, TLAST error and one-cycle pulses
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_num         <= '0;
      r_idx         <= '0;
      r_wcnt        <= '0;
      r_err         <= 1'b0;
      r_zero_done   <= 1'b0;
      r_abort_pulse <= 1'b0;
      r_conv_start  <= 1'b0;
    end else begin
      r_zero_done   <= (r_state == ST_IDLE) && START && (NUM_FILTERS == '0);
      r_abort_pulse <= w_abort;
      r_conv_start  <= (r_state == ST_WAIT_FULL) && bus.WB_FULL && !ABORT;
      if (w_start_ok) begin
        r_num  <= NUM_FILTERS;
        r_idx  <= '0;
        r_wcnt <= '0;
        r_err  <= 1'b0;
      end else if (w_abort) begin
        // ERR_LAST deliberately survives an abort; only a new run clears it
        r_idx  <= '0;
        r_wcnt <= '0;
      end else begin
        if (w_beat) begin
          r_wcnt <= w_kernel_end ? '0 : r_wcnt + WCW'(1);
          if (bus.S_TLAST != w_final_beat) begin
            r_err <= 1'b1;
          end
        end
        if ((r_state == ST_CONV) && bus.CONV_DONE && !w_last_filter) begin
          r_idx <= r_idx + CNT_ONE;
        end
      end
    end
  end

  // outputs; reset gates the handshakes so nothing leaks before the first clock edge of reset
  always_comb begin
    bus.S_TREADY    = RESETN && (r_state == ST_LOAD);
    bus.WB_WR_EN    = RESETN && (r_state == ST_LOAD);
    bus.WB_WR_VALID = RESETN && (r_state == ST_LOAD) && bus.S_TVALID;
    bus.WB_WR_DATA  = w_tdata;
    bus.WB_RESETN   = RESETN && !r_abort_pulse;
    bus.CONV_START  = RESETN && r_conv_start;
    BUSY            = RESETN && w_busy_state;
    DONE            = RESETN && (((r_state == ST_FINISH) && !ABORT) || r_zero_done);
    ERR_LAST        = r_err;
    FILTER_IDX      = r_idx;
  end

endmodule
